// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier-mode sequencer.
//   DEF_WIDTH / DEF_BCD_DIGITS : default operand width and BCD digit count
//   state_e                    : sequencer FSM states
//   add3_if_ge5                : double-dabble nibble correction
package mult_pkg;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_BCD_DIGITS = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    BCD  = 2'd2,
    DONE = 2'd3
  } state_e;

  // A BCD nibble of 5..9 would become >= 10 after the following doubling,
  // so pre-add 3 to make the carry land in the next digit.
  function automatic logic [3:0] add3_if_ge5(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one bit per cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle pulse, loads bin and performs the first step
//   abort      : discard any conversion in progress (no done pulse)
//   bin        : 2*WIDTH-bit binary input, sampled with start
//   bcd        : 4*BCD_DIGITS-bit result, valid from the done cycle on
//   done       : one-cycle pulse, 2*WIDTH cycles after start
module bin2bcd_seq
  import mult_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int BCD_DIGITS = DEF_BCD_DIGITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [2*WIDTH-1:0]        bin,
  output logic [4*BCD_DIGITS-1:0]   bcd,
  output logic                      done
);

  localparam int BW = 2 * WIDTH;
  localparam int DW = 4 * BCD_DIGITS;
  localparam int SW = DW + BW;
  localparam int CW = $clog2(BW);
  localparam logic [CW-1:0] LAST = CW'(BW - 1);

  logic [SW-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic          done_q, done_d;

  // One double-dabble iteration: correct every BCD nibble, then shift left.
  function automatic logic [SW-1:0] dd_step(input logic [SW-1:0] s);
    logic [SW-1:0] t;
    t = s;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      t[BW + 4*i +: 4] = add3_if_ge5(s[BW + 4*i +: 4]);
    end
    return t << 1;
  endfunction

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    done_d  = 1'b0;
    if (abort) begin
      shift_d = '0;
      cnt_d   = '0;
      run_d   = 1'b0;
    end else if (start) begin
      // The first step happens on the load edge so that the final step and
      // the done pulse coincide after exactly BW cycles.
      shift_d = dd_step({{DW{1'b0}}, bin});
      cnt_d   = CW'(1);
      run_d   = 1'b1;
    end else if (run_q) begin
      shift_d = dd_step(shift_q);
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

  assign bcd  = shift_q[SW-1 -: DW];
  assign done = done_q;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Multiplier-mode sequencer: operand entry from key pulses, iterative
// shift-add multiply, then sequential BCD conversion of the product.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   enable              : multiplier mode selected (gates key pulses only)
//   x_inc, y_inc        : one-cycle pulses, increment X / Y modulo 2^WIDTH
//   start               : one-cycle pulse, begin X*Y
//   clr                 : one-cycle pulse, abort and clear everything
//   x_out, y_out        : current operands
//   product, bcd        : last completed product and its BCD digits
//   busy, done, valid   : in progress / completion pulse / result held
// All outputs are registered.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int BCD_DIGITS = DEF_BCD_DIGITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    x_inc,
  input  logic                    y_inc,
  input  logic                    start,
  input  logic                    clr,
  output logic [WIDTH-1:0]        x_out,
  output logic [WIDTH-1:0]        y_out,
  output logic [2*WIDTH-1:0]      product,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic                    busy,
  output logic                    done,
  output logic                    valid
);

  localparam int PW = 2 * WIDTH;
  localparam int DW = 4 * BCD_DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    product_q, product_d;
  logic [DW-1:0]    bcd_q, bcd_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             conv_start;
  logic [DW-1:0]    conv_bcd;
  logic             conv_done;
  logic             keys_ok;

  // Converter takes acc_d so it sees the product including the last
  // partial sum added on the same edge.
  bin2bcd_seq #(
    .WIDTH      (WIDTH),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .abort (clr),
    .bin   (acc_d),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    product_d  = product_q;
    bcd_d      = bcd_q;
    valid_d    = valid_q;
    conv_start = 1'b0;
    keys_ok    = enable && (state_q == IDLE || state_q == DONE);

    if (clr) begin
      state_d   = IDLE;
      x_d       = '0;
      y_d       = '0;
      mcand_d   = '0;
      mplier_d  = '0;
      acc_d     = '0;
      cnt_d     = '0;
      product_d = '0;
      bcd_d     = '0;
      valid_d   = 1'b0;
    end else begin
      // Start takes precedence over key increments in the same cycle.
      if (state_q == IDLE && start && enable) begin
        state_d   = MUL;
        mcand_d   = {{(PW-WIDTH){1'b0}}, x_q};
        mplier_d  = y_q;
        acc_d     = '0;
        cnt_d     = '0;
        product_d = '0;
        bcd_d     = '0;
        valid_d   = 1'b0;
      end else if (keys_ok) begin
        if (x_inc) x_d = x_q + WIDTH'(1);
        if (y_inc) y_d = y_q + WIDTH'(1);
      end

      unique case (state_q)
        IDLE: ;
        MUL: begin
          acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (cnt_q == LAST) begin
            cnt_d      = '0;
            state_d    = BCD;
            conv_start = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        BCD: begin
          if (conv_done) begin
            state_d   = DONE;
            product_d = acc_q;
            bcd_d     = conv_bcd;
            valid_d   = 1'b1;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == MUL) || (state_d == BCD);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      bcd_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      bcd_q     <= bcd_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign x_out   = x_q;
  assign y_out   = y_q;
  assign product = product_q;
  assign bcd     = bcd_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl (WIDTH=4, BCD_DIGITS=3).
module tb_mult_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        x_inc;
  logic        y_inc;
  logic        start;
  logic        clr;
  logic [3:0]  x_out;
  logic [3:0]  y_out;
  logic [7:0]  product;
  logic [11:0] bcd;
  logic        busy;
  logic        done;
  logic        valid;

  int checks   = 0;
  int failures = 0;

  // Results of the last run_mul call; cycle 1 is the cycle after the
  // edge that sampled start.
  int busy_cnt;
  int first_busy;
  int done_cnt;
  int done_at;
  logic busy_after;

  mult_seq_ctrl #(.WIDTH(4), .BCD_DIGITS(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .x_inc   (x_inc),
    .y_inc   (y_inc),
    .start   (start),
    .clr     (clr),
    .x_out   (x_out),
    .y_out   (y_out),
    .product (product),
    .bcd     (bcd),
    .busy    (busy),
    .done    (done),
    .valid   (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit is_x, input int n);
    for (int i = 0; i < n; i++) begin
      if (is_x) x_inc = 1'b1; else y_inc = 1'b1;
      tick();
      x_inc = 1'b0;
      y_inc = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // act_kind: 0 none, 1 start pulse, 2 drop enable, 3 clr pulse (at act_cycle)
  task automatic run_mul(input int act_cycle, input int act_kind, input bit with_xinc);
    start = 1'b1;
    x_inc = with_xinc;
    tick();
    start = 1'b0;
    x_inc = 1'b0;
    busy_cnt   = 0;
    first_busy = 0;
    done_cnt   = 0;
    done_at    = 0;
    busy_after = 1'bx;
    for (int c = 1; c <= 16; c++) begin
      if (busy === 1'b1) begin
        busy_cnt++;
        if (first_busy == 0) first_busy = c;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      if (c == act_cycle + 1) busy_after = busy;
      if (c == act_cycle) begin
        case (act_kind)
          1: start  = 1'b1;
          2: enable = 1'b0;
          3: clr    = 1'b1;
          default: ;
        endcase
      end
      tick();
      start = 1'b0;
      clr   = 1'b0;
    end
    $display("run x=%0d y=%0d product=%0d bcd=%03h busy_cycles=%0d done_pulses=%0d done_at=%0d",
             x_out, y_out, product, bcd, busy_cnt, done_cnt, done_at);
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    x_inc  = 1'b0;
    y_inc  = 1'b0;
    start  = 1'b0;
    clr    = 1'b0;
    repeat (3) tick();
    check("rst_x",       x_out,   0);
    check("rst_y",       y_out,   0);
    check("rst_product", product, 0);
    check("rst_bcd",     bcd,     0);
    check("rst_busy",    busy,    0);
    check("rst_done",    done,    0);
    check("rst_valid",   valid,   0);
    rst_n = 1'b1;
    tick();

    // 3 * 5
    press(1'b1, 3);
    press(1'b0, 5);
    check("t1_x", x_out, 3);
    check("t1_y", y_out, 5);
    run_mul(0, 0, 1'b0);
    check("t1_first_busy", first_busy, 1);
    check("t1_busy_cycles", busy_cnt, 12);
    check("t1_done_pulses", done_cnt, 1);
    check("t1_done_at", done_at, 13);
    check("t1_product", product, 15);
    check("t1_bcd", bcd, 12'h015);
    check("t1_valid", valid, 1);

    // 15 * 15, then X wraps and valid holds
    pulse_clr();
    press(1'b1, 15);
    press(1'b0, 15);
    check("t2_x", x_out, 15);
    run_mul(0, 0, 1'b0);
    check("t2_product", product, 8'hE1);
    check("t2_bcd", bcd, 12'h225);
    press(1'b1, 1);
    $display("xinc after done x=%0d valid=%0d", x_out, valid);
    check("t2_x_wrap", x_out, 0);
    check("t2_valid_hold", valid, 1);

    // 0 * 9 with an ignored second start
    pulse_clr();
    press(1'b0, 9);
    run_mul(5, 1, 1'b0);
    check("t3_done_pulses", done_cnt, 1);
    check("t3_done_at", done_at, 13);
    check("t3_product", product, 0);
    check("t3_bcd", bcd, 12'h000);
    check("t3_valid", valid, 1);

    // 7 * 6 with enable dropped mid-run
    pulse_clr();
    press(1'b1, 7);
    press(1'b0, 6);
    run_mul(4, 2, 1'b0);
    check("t4_done_at", done_at, 13);
    check("t4_product", product, 42);
    check("t4_bcd", bcd, 12'h042);
    press(1'b1, 1);
    $display("xinc with enable=0 x=%0d", x_out);
    check("t4_x_gated", x_out, 7);
    enable = 1'b1;

    // 12 * 11 aborted by clr
    pulse_clr();
    press(1'b1, 12);
    press(1'b0, 11);
    run_mul(6, 3, 1'b0);
    check("t5_busy_after_clr", busy_after, 0);
    check("t5_done_pulses", done_cnt, 0);
    check("t5_x", x_out, 0);
    check("t5_y", y_out, 0);
    check("t5_product", product, 0);
    check("t5_bcd", bcd, 0);
    check("t5_valid", valid, 0);

    // 12 * 11 interrupted by asynchronous reset during BCD
    press(1'b1, 12);
    press(1'b0, 11);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();          // now in cycle 8, inside the BCD phase
    check("t5b_busy_pre", busy, 1);
    check("t5b_x_pre", x_out, 12);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset mid-BCD x=%0d y=%0d busy=%0d", x_out, y_out, busy);
    check("t5b_x", x_out, 0);
    check("t5b_y", y_out, 0);
    check("t5b_busy", busy, 0);
    check("t5b_valid", valid, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // start and x_inc together: start wins with X=2
    press(1'b1, 2);
    press(1'b0, 3);
    run_mul(0, 0, 1'b1);
    check("t6_product", product, 6);
    check("t6_bcd", bcd, 12'h006);
    check("t6_x", x_out, 2);
    check("t6_done_at", done_at, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Sequencer for the 4-bit multiplier mode: owns operands X/Y, key-driven operand entry, an iterative shift-add multiply, and a sequential binary-to-BCD conversion of the product.
- Sits between the key distribution logic (debounced one-cycle pulses) and the segment data/select logic.
- Presents X, Y, the product and its three BCD digits with a start/busy/done handshake, so the display never sees a partial result.

Parameters:
- WIDTH, 4, operand width; legal range 2..4 (product ≤ 225, so three BCD digits).
- BCD_DIGITS, 3, number of BCD output digits; fixed for the legal WIDTH range.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  multiplier mode selected; gates key pulses only
- x_inc  in  1  one-cycle pulse: X <= X+1
- y_inc  in  1  one-cycle pulse: Y <= Y+1
- start  in  1  one-cycle pulse: begin X*Y
- clr  in  1  one-cycle pulse: abort and clear everything
- x_out  out  WIDTH  current operand X
- y_out  out  WIDTH  current operand Y
- product  out  2*WIDTH  last completed product
- bcd  out  4*BCD_DIGITS  {hundreds, tens, ones} of product
- busy  out  1  computation in progress
- done  out  1  one-cycle completion pulse
- valid  out  1  product/bcd hold a completed result

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, internal counters 0.
- FSM states: IDLE, MUL, BCD, DONE.
- IDLE -> MUL: start & enable & !clr.
  - Latch X and Y into working registers; clear the accumulator, product, bcd and valid.
- MUL (WIDTH cycles): each cycle, if the multiplier LSB is 1, acc += multiplicand (2*WIDTH bits, no overflow possible). Then shift the multiplicand left and the multiplier right. After WIDTH cycles, go to BCD.
- BCD (2*WIDTH cycles): double-dabble on {bcd_shift, acc}. Each cycle:
  - add 3 to any BCD nibble ≥ 5,
  - then shift left 1.
  - After 2*WIDTH cycles, go to DONE.
- DONE (1 cycle): done=1; product and bcd are registered; valid set to 1. Then return to IDLE.
- busy=1 exactly in MUL and BCD.
- Latency: start sampled at edge k. busy is high during cycles k+1 .. k+3*WIDTH. done is high during cycle k+3*WIDTH+1 (cycle 13 for WIDTH=4). product, bcd and valid are stable from that cycle on.
- Operand entry (IDLE or DONE only, enable=1):
  - x_inc/y_inc increment modulo 2^WIDTH (15 -> 0).
  - x_inc and y_inc in the same cycle are both applied.
  - Increments while busy are dropped.
- start while busy, or with enable=0: ignored.
- start and x_inc/y_inc in the same cycle: start wins, uses pre-increment operands, increments dropped.
- clr (any state, regardless of enable): highest priority. Next state IDLE; X, Y, product, bcd, valid, busy, done all return to 0. An in-flight computation is discarded with no done pulse.
- enable deasserted mid-computation: computation runs to completion and done still pulses. Only new key pulses are gated.
- valid stays 1 until the next accepted start or clr. Operand changes after completion do not clear valid.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package mult_pkg:
  - state enum {IDLE, MUL, BCD, DONE},
  - WIDTH and BCD_DIGITS defaults,
  - function add3_if_ge5 (nibble correction).
- One natural sub-module: bin2bcd_seq.
  - Sequential double-dabble with its own start/done handshake; input 2*WIDTH bits, output 4*BCD_DIGITS bits.
  - Fixed latency of 2*WIDTH cycles.
  - mult_seq_ctrl's BCD state waits on its done.
- The shift-add multiply stays in the top FSM.

Test Plan:
- Reset, then 3 x_inc and 5 y_inc pulses with enable=1; start -> busy high for 12 cycles; done pulses on cycle 13; product=15, bcd=0x015, valid=1.
- X=15, Y=15 (15 pulses each) then start -> product=225 (0xE1), bcd=0x225. One further x_inc -> x_out=0 and valid stays 1.
- X=0, Y=9, start -> product=0, bcd=0x000, done pulses at cycle 13. A second start on cycle 5 of busy is ignored, so exactly one done pulse occurs.
- X=7, Y=6: start; enable dropped at cycle 4 -> done still pulses at cycle 13, product=42, bcd=0x042. x_inc with enable=0 afterwards leaves x_out=7.
- X=12, Y=11: start; clr at cycle 6 -> busy=0 next cycle, no done pulse, x_out=y_out=product=bcd=valid=0. rst_n asserted mid-BCD -> all outputs 0 immediately, without waiting for a clock edge.
- start and x_inc in the same cycle with X=2, Y=3 -> product=6, x_out stays 2.
